sync_fifo_param: RTL and testbench

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

---
 rtl/sync_fifo_param.sv | 207 ++++++++++++++++++++
 tb/tb_sync_fifo_param.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Parameterised synchronous FIFO with threshold flags and sticky overflow/underflow errors.
// Optional macro SYNC_FIFO_FWFT_EN selects first-word-fall-through output; undefined gives registered-read mode.
module sync_fifo_param #(
   parameter int SIZE     = 4,
   parameter int WIDTH    = 8,
   parameter int AF_LEVEL = 12,
   parameter int AE_LEVEL = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             write_en,
   input  logic [WIDTH-1:0] data_in,
   input  logic             read_en,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   output logic             fifo_full,
   output logic             fifo_empty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic [SIZE:0]    fill_count,
   output logic             overflow,
   output logic             underflow,
   input  logic             clr_err
);

   localparam int            DEPTH  = 1 << SIZE;
   localparam logic [SIZE:0] ZERO_L  = {(SIZE+1){1'b0}};
   localparam logic [SIZE:0] ONE_L   = {{SIZE{1'b0}}, 1'b1};
   localparam logic [SIZE:0] DEPTH_L = {1'b1, {SIZE{1'b0}}};
   localparam logic [SIZE:0] AF_L    = AF_LEVEL[SIZE:0];
   localparam logic [SIZE:0] AE_L    = AE_LEVEL[SIZE:0];

   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [SIZE:0]    wr_ptr_q, wr_ptr_d;
   logic [SIZE:0]    rd_ptr_q, rd_ptr_d;
   logic [SIZE:0]    fill_q, fill_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             dvalid_q, dvalid_d;
   logic             ovf_q, ovf_d;
   logic             udf_q, udf_d;

   logic             empty_s, full_s;
   logic             rd_acc_s, wr_acc_s;
   logic             ovf_set_s, udf_set_s;
   logic [SIZE-1:0]  wr_idx_s;

   // Acceptance decode; a read frees a slot so a write on full still goes through.
   always_comb begin
      empty_s   = (fill_q == ZERO_L);
      full_s    = (fill_q == DEPTH_L);
      rd_acc_s  = read_en & ~empty_s;
      wr_acc_s  = write_en & (~full_s | rd_acc_s);
      ovf_set_s = write_en & ~wr_acc_s;
      udf_set_s = read_en & empty_s;
      wr_idx_s  = wr_ptr_q[SIZE-1:0];
   end

   // Pointer, occupancy and sticky error next-state; a new error beats clr_err.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      fill_d   = fill_q;
      ovf_d    = ovf_q;
      udf_d    = udf_q;

      if (wr_acc_s) begin
         wr_ptr_d = wr_ptr_q + ONE_L;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (rd_acc_s) begin
         rd_ptr_d = rd_ptr_q + ONE_L;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      case ({wr_acc_s, rd_acc_s})
         2'b10:   fill_d = fill_q + ONE_L;
         2'b01:   fill_d = fill_q - ONE_L;
         default: fill_d = fill_q;
      endcase

      if (ovf_set_s) begin
         ovf_d = 1'b1;
      end else if (clr_err) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end

      if (udf_set_s) begin
         udf_d = 1'b1;
      end else if (clr_err) begin
         udf_d = 1'b0;
      end else begin
         udf_d = udf_q;
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   logic [SIZE-1:0] rd_idx_nxt_s;

   // Registered head word: the word at the post-edge read pointer, bypassing a write landing there.
   always_comb begin
      rd_idx_nxt_s = rd_ptr_d[SIZE-1:0];
      dvalid_d     = (fill_d != ZERO_L);
      if (fill_d == ZERO_L) begin
         dout_d = dout_q;
      end else if (wr_acc_s && (wr_idx_s == rd_idx_nxt_s)) begin
         dout_d = data_in;
      end else begin
         dout_d = mem_q[rd_idx_nxt_s];
      end
   end
`else
   logic [SIZE-1:0] rd_idx_s;

   // Registered read: capture the head on an accepted pop, pulse valid for one cycle.
   always_comb begin
      rd_idx_s = rd_ptr_q[SIZE-1:0];
      dvalid_d = rd_acc_s;
      if (rd_acc_s) begin
         dout_d = mem_q[rd_idx_s];
      end else begin
         dout_d = dout_q;
      end
   end
`endif

   // Storage write; the array itself is not reset.
   always_ff @(posedge clk) begin
      if (rst_n && wr_acc_s) begin
         mem_q[wr_idx_s] <= data_in;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= ZERO_L;
         rd_ptr_q <= ZERO_L;
         fill_q   <= ZERO_L;
         dout_q   <= {WIDTH{1'b0}};
         dvalid_q <= 1'b0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fill_q   <= fill_d;
         dout_q   <= dout_d;
         dvalid_q <= dvalid_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   // Status flags decode registered occupancy; reset forces the empty view.
   always_comb begin
      data_out     = dout_q;
      data_valid   = dvalid_q;
      fill_count   = fill_q;
      overflow     = ovf_q;
      underflow    = udf_q;
      fifo_empty   = ~rst_n | empty_s;
      almost_empty = ~rst_n | (fill_q <= AE_L);
      fifo_full    = rst_n & full_s;
      almost_full  = rst_n & (fill_q >= AF_L);
   end

   sync_fifo_param_chk #(.SIZE(SIZE)) u_chk (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_ptr (wr_ptr_q),
      .rd_ptr (rd_ptr_q),
      .fill   (fill_q),
      .full   (full_s),
      .empty  (empty_s)
   );

endmodule

// Structural invariants of the FIFO bookkeeping.
module sync_fifo_param_chk #(
   parameter int SIZE = 4
) (
   input logic          clk,
   input logic          rst_n,
   input logic [SIZE:0] wr_ptr,
   input logic [SIZE:0] rd_ptr,
   input logic [SIZE:0] fill,
   input logic          full,
   input logic          empty
);

   localparam logic [SIZE:0] DEPTH_L = {1'b1, {SIZE{1'b0}}};

   a_fill_ptr : assert property (@(posedge clk) disable iff (!rst_n) fill == (wr_ptr - rd_ptr))
      else $error("fill_count inconsistent with pointers");
   a_fill_max : assert property (@(posedge clk) disable iff (!rst_n) fill <= DEPTH_L)
      else $error("fill_count above depth");
   a_full_empty : assert property (@(posedge clk) disable iff (!rst_n) !(full && empty))
      else $error("full and empty together");

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param with a queue scoreboard and per-cycle flag model.
module tb_sync_fifo_param;

   localparam int DEPTH = 16;
   localparam int AF    = 12;
   localparam int AE    = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       write_en;
   logic [7:0] data_in;
   logic       read_en;
   logic [7:0] data_out;
   logic       data_valid;
   logic       fifo_full;
   logic       fifo_empty;
   logic       almost_full;
   logic       almost_empty;
   logic [4:0] fill_count;
   logic       overflow;
   logic       underflow;
   logic       clr_err;

   int         checks   = 0;
   int         failures = 0;
   logic [7:0] sb_q[$];
   logic       m_ovf;
   logic       m_udf;
   logic [7:0] m_dout;

   always #5 clk = ~clk;

   sync_fifo_param dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .write_en     (write_en),
      .data_in      (data_in),
      .read_en      (read_en),
      .data_out     (data_out),
      .data_valid   (data_valid),
      .fifo_full    (fifo_full),
      .fifo_empty   (fifo_empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .fill_count   (fill_count),
      .overflow     (overflow),
      .underflow    (underflow),
      .clr_err      (clr_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string tag);
      int n;
      n = sb_q.size();
      chk({tag, ":fill"},   32'(fill_count),   32'(n));
      chk({tag, ":full"},   32'(fifo_full),    32'(n == DEPTH));
      chk({tag, ":empty"},  32'(fifo_empty),   32'(n == 0));
      chk({tag, ":afull"},  32'(almost_full),  32'(n >= AF));
      chk({tag, ":aempty"}, 32'(almost_empty), 32'(n <= AE));
      chk({tag, ":ovf"},    32'(overflow),     32'(m_ovf));
      chk({tag, ":udf"},    32'(underflow),    32'(m_udf));
   endtask

   task automatic do_cycle(input logic we, input logic [7:0] din, input logic re,
                           input logic clr, input string tag);
      logic       full_m;
      logic       empty_m;
      logic       rd_acc;
      logic       wr_acc;
      logic [7:0] exp_w;
      full_m  = (sb_q.size() == DEPTH);
      empty_m = (sb_q.size() == 0);
      rd_acc  = re && !empty_m;
      wr_acc  = we && (!full_m || rd_acc);
      exp_w   = 8'h00;
`ifdef SYNC_FIFO_FWFT_EN
      if (rd_acc) chk({tag, ":head"}, 32'(data_out), 32'(sb_q[0]));
`endif
      write_en = we;
      data_in  = din;
      read_en  = re;
      clr_err  = clr;
      step();
      write_en = 1'b0;
      read_en  = 1'b0;
      clr_err  = 1'b0;
      if (rd_acc) exp_w = sb_q.pop_front();
      if (wr_acc) sb_q.push_back(din);
      m_ovf = (we && !wr_acc) ? 1'b1 : (clr ? 1'b0 : m_ovf);
      m_udf = (re && empty_m) ? 1'b1 : (clr ? 1'b0 : m_udf);
`ifdef SYNC_FIFO_FWFT_EN
      chk({tag, ":valid"}, 32'(data_valid), 32'(sb_q.size() != 0));
      if (sb_q.size() != 0) chk({tag, ":dout"}, 32'(data_out), 32'(sb_q[0]));
`else
      if (rd_acc) m_dout = exp_w;
      chk({tag, ":valid"}, 32'(data_valid), 32'(rd_acc));
      chk({tag, ":dout"},  32'(data_out),   32'(m_dout));
`endif
      check_state(tag);
   endtask

   task automatic do_reset(input string tag);
      rst_n    = 1'b0;
      write_en = 1'b1;
      read_en  = 1'b1;
      clr_err  = 1'b0;
      data_in  = 8'hEE;
      step();
      sb_q.delete();
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      m_dout = 8'h00;
      check_state(tag);
      chk({tag, ":valid"}, 32'(data_valid), 32'd0);
      chk({tag, ":dout"},  32'(data_out),   32'd0);
      rst_n    = 1'b1;
      write_en = 1'b0;
      read_en  = 1'b0;
   endtask

   initial begin
      rst_n    = 1'b0;
      write_en = 1'b1;
      read_en  = 1'b1;
      clr_err  = 1'b1;
      data_in  = 8'hEE;
      m_ovf    = 1'b0;
      m_udf    = 1'b0;
      m_dout   = 8'h00;
      step();
      do_reset("reset");

      // Read on empty after reset
      do_cycle(1'b0, 8'h00, 1'b1, 1'b0, "rd_empty");
      do_cycle(1'b0, 8'h00, 1'b0, 1'b1, "clr_udf");

      // Fill to full, almost_full from count 12
      for (int i = 1; i <= 16; i++) do_cycle(1'b1, 8'(i), 1'b0, 1'b0, "fill");

      // Write on full is dropped, drain returns original order
      do_cycle(1'b1, 8'hAA, 1'b0, 1'b0, "wr_full");
      for (int i = 0; i < 16; i++) do_cycle(1'b0, 8'h00, 1'b1, 1'b0, "drain1");
      do_cycle(1'b0, 8'h00, 1'b0, 1'b1, "clr_ovf");

      // Full with simultaneous write and read, across pointer wrap
      for (int i = 0; i < 16; i++) do_cycle(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0, "refill");
      for (int i = 0; i < 20; i++) do_cycle(1'b1, 8'h55, 1'b1, 1'b0, "full_wr_rd");
      for (int i = 0; i < 16; i++) do_cycle(1'b0, 8'h00, 1'b1, 1'b0, "drain2");

      // Single word latency
      do_cycle(1'b1, 8'h3C, 1'b0, 1'b0, "wr_3c");
      do_cycle(1'b0, 8'h00, 1'b1, 1'b0, "rd_3c");
      do_cycle(1'b0, 8'h00, 1'b0, 1'b0, "idle_3c");

      // Write and read on empty: write only, underflow set
      do_cycle(1'b1, 8'h77, 1'b1, 1'b0, "empty_wr_rd");
      do_cycle(1'b0, 8'h00, 1'b1, 1'b1, "rd_77_clr");

      // New error wins over clr_err
      do_cycle(1'b0, 8'h00, 1'b1, 1'b1, "clr_vs_udf");
      do_cycle(1'b0, 8'h00, 1'b0, 1'b1, "clr_udf2");

      // Reset mid-operation discards contents
      for (int i = 0; i < 8; i++) do_cycle(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0, "pre_rst");
      do_reset("mid_reset");
      do_cycle(1'b0, 8'h00, 1'b1, 1'b0, "rd_after_rst");
      do_cycle(1'b1, 8'h5A, 1'b0, 1'b0, "wr_after_rst");
      do_cycle(1'b0, 8'h00, 1'b1, 1'b0, "rd_5a");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
